pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer : debug run/step/halt sequencer gating the PC register enable.
// Optional cycle counter built only when PC_SEQ_CYCLE_COUNT_EN is defined.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pc_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_code,
    input  logic [7:0]  step_count,
    input  logic        stall,
    input  logic        halt_instr,
    output logic        db_we,
    output logic        pc_write,
    output logic        pc_clear,
    output logic        done,
    output logic        cmd_err,
    output logic [1:0]  state,
    output logic [31:0] cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_STEP   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [1:0] CMD_STOP  = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    state_t     state_q;
    logic [7:0] step_cnt_q;
    logic       db_we_q;
    logic       done_q;
    logic       cmd_err_q;
    logic       pc_clear_q;

    assign pc_write = db_we_q & ~stall & ~halt_instr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            step_cnt_q <= 8'd0;
            db_we_q    <= 1'b0;
            done_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
            pc_clear_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
            pc_clear_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_code)
                            CMD_RUN: begin
                                state_q <= S_RUN;
                                db_we_q <= 1'b1;
                            end
                            CMD_STEP: begin
                                if (step_count != 8'd0) begin
                                    state_q    <= S_STEP;
                                    db_we_q    <= 1'b1;
                                    step_cnt_q <= step_count;
                                end else begin
                                    cmd_err_q <= 1'b1;
                                end
                            end
                            CMD_CLEAR: pc_clear_q <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                S_RUN, S_STEP: begin
                    // A decoded HALT outranks everything, including a coincident STOP or final step.
                    if (halt_instr) begin
                        state_q    <= S_HALTED;
                        db_we_q    <= 1'b0;
                        done_q     <= 1'b1;
                        step_cnt_q <= 8'd0;
                    end else if (cmd_valid && (cmd_code == CMD_STOP)) begin
                        state_q    <= S_IDLE;
                        db_we_q    <= 1'b0;
                        done_q     <= 1'b1;
                        step_cnt_q <= 8'd0;
                    end else begin
                        if (cmd_valid) begin
                            cmd_err_q <= 1'b1;
                        end
                        if ((state_q == S_STEP) && pc_write) begin
                            if (step_cnt_q == 8'd1) begin
                                state_q    <= S_IDLE;
                                db_we_q    <= 1'b0;
                                done_q     <= 1'b1;
                                step_cnt_q <= 8'd0;
                            end else begin
                                step_cnt_q <= step_cnt_q - 8'd1;
                            end
                        end
                    end
                end
                S_HALTED: begin
                    if (cmd_valid) begin
                        case (cmd_code)
                            CMD_CLEAR: begin
                                pc_clear_q <= 1'b1;
                                state_q    <= S_IDLE;
                            end
                            CMD_RUN, CMD_STEP: cmd_err_q <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    db_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign state    = state_q;
    assign db_we    = db_we_q;
    assign done     = done_q;
    assign cmd_err  = cmd_err_q;
    assign pc_clear = pc_clear_q;

`ifdef PC_SEQ_CYCLE_COUNT_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] cycle_cnt_d;
    logic        clear_accept;

    // CLEAR is only honoured (and only clears the count) from IDLE or HALTED.
    assign clear_accept = cmd_valid && (cmd_code == CMD_CLEAR) &&
                          ((state_q == S_IDLE) || (state_q == S_HALTED));

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (clear_accept) begin
            cycle_cnt_d = 32'd0;
        end else if (pc_write) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign cycle_count = cycle_cnt_q;
`else
    assign cycle_count = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: linear command sequence with hand-computed expectations.
`default_nettype none

module tb_pc_sequencer;

    localparam logic [1:0] STOP  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] STEP  = 2'b10;
    localparam logic [1:0] CLEAR = 2'b11;

`ifdef PC_SEQ_CYCLE_COUNT_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_code = 2'b00;
    logic [7:0]  step_count = 8'd0;
    logic        stall = 1'b0;
    logic        halt_instr = 1'b0;
    logic        db_we;
    logic        pc_write;
    logic        pc_clear;
    logic        done;
    logic        cmd_err;
    logic [1:0]  state;
    logic [31:0] cycle_count;

    int n_assert = 0;
    int n_fail   = 0;
    int n_db, n_pw, n_done, n_err, n_clr, last_done;

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .step_count  (step_count),
        .stall       (stall),
        .halt_instr  (halt_instr),
        .db_we       (db_we),
        .pc_write    (pc_write),
        .pc_clear    (pc_clear),
        .done        (done),
        .cmd_err     (cmd_err),
        .state       (state),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ecc(input logic [31:0] v);
        return CC_EN ? v : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [1:0] c, input logic [7:0] s);
        cmd_valid  = 1'b1;
        cmd_code   = c;
        step_count = s;
    endtask

    // Run n cycles with a pending command consumed on the first edge; tally outputs each cycle.
    task automatic observe(input int n, input logic [15:0] stall_m, input logic [15:0] halt_m);
        n_db = 0; n_pw = 0; n_done = 0; n_err = 0; n_clr = 0; last_done = -1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cmd_valid  = 1'b0;
            stall      = stall_m[i];
            halt_instr = halt_m[i];
            #1;
            if (db_we)    n_db++;
            if (pc_write) n_pw++;
            if (done)     begin n_done++; last_done = i; end
            if (cmd_err)  n_err++;
            if (pc_clear) n_clr++;
        end
        stall      = 1'b0;
        halt_instr = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_db_we", {31'd0, db_we}, 32'd0);
        chk("rst_pc_write", {31'd0, pc_write}, 32'd0);
        chk("rst_pulses", {29'd0, done, cmd_err, pc_clear}, 32'd0);
        chk("rst_cc", cycle_count, 32'd0);
        tick();
        tick();
        rst = 1'b1;

        // STEP 3, no stall
        set_cmd(STEP, 8'd3);
        observe(6, 16'h0000, 16'h0000);
        chk("step3_db", n_db, 32'd3);
        chk("step3_pw", n_pw, 32'd3);
        chk("step3_done", n_done, 32'd1);
        chk("step3_done_at", last_done, 32'd3);
        chk("step3_state", {30'd0, state}, 32'd0);
        chk("step3_cc", cycle_count, ecc(32'd3));

        // STEP 2 with a two-cycle stall mid-step
        set_cmd(STEP, 8'd2);
        observe(7, 16'h0006, 16'h0000);
        chk("step2s_db", n_db, 32'd4);
        chk("step2s_pw", n_pw, 32'd2);
        chk("step2s_done", n_done, 32'd1);
        chk("step2s_done_at", last_done, 32'd4);
        chk("step2s_cc", cycle_count, ecc(32'd5));

        // RUN, HALT decoded on the fifth RUN cycle
        set_cmd(RUN, 8'd0);
        observe(7, 16'h0000, 16'h0010);
        chk("halt_db", n_db, 32'd5);
        chk("halt_pw", n_pw, 32'd4);
        chk("halt_done", n_done, 32'd1);
        chk("halt_state", {30'd0, state}, 32'd3);
        chk("halt_cc", cycle_count, ecc(32'd9));

        set_cmd(RUN, 8'd0);
        observe(3, 16'h0000, 16'h0000);
        chk("halted_run_err", n_err, 32'd1);
        chk("halted_run_state", {30'd0, state}, 32'd3);
        chk("halted_run_db", n_db, 32'd0);

        set_cmd(STOP, 8'd0);
        observe(2, 16'h0000, 16'h0000);
        chk("halted_stop_state", {30'd0, state}, 32'd3);
        chk("halted_stop_err", n_err, 32'd0);

        set_cmd(CLEAR, 8'd0);
        observe(3, 16'h0000, 16'h0000);
        chk("clear_pulse", n_clr, 32'd1);
        chk("clear_state", {30'd0, state}, 32'd0);
        chk("clear_cc", cycle_count, 32'd0);

        // STEP with zero count is rejected
        set_cmd(STEP, 8'd0);
        observe(3, 16'h0000, 16'h0000);
        chk("step0_err", n_err, 32'd1);
        chk("step0_state", {30'd0, state}, 32'd0);
        chk("step0_db", n_db, 32'd0);

        // RUN during STEP is rejected while stepping continues
        set_cmd(STEP, 8'd3);
        tick();
        cmd_valid = 1'b0;
        tick();
        set_cmd(RUN, 8'd0);
        tick();
        cmd_valid = 1'b0;
        chk("step_run_err", {31'd0, cmd_err}, 32'd1);
        chk("step_run_state", {30'd0, state}, 32'd2);
        tick();
        chk("step_run_end_state", {30'd0, state}, 32'd0);
        chk("step_run_done", {31'd0, done}, 32'd1);
        chk("step_run_err_clr", {31'd0, cmd_err}, 32'd0);
        chk("step_run_cc", cycle_count, ecc(32'd3));

        // STOP during RUN
        set_cmd(RUN, 8'd0);
        tick();
        cmd_valid = 1'b0;
        tick();
        set_cmd(STOP, 8'd0);
        tick();
        cmd_valid = 1'b0;
        chk("stop_state", {30'd0, state}, 32'd0);
        chk("stop_done", {31'd0, done}, 32'd1);
        chk("stop_db", {31'd0, db_we}, 32'd0);
        chk("stop_cc", cycle_count, ecc(32'd5));
        tick();
        chk("stop_done_width", {31'd0, done}, 32'd0);

        // HALT coincident with the last step
        set_cmd(STEP, 8'd1);
        tick();
        cmd_valid  = 1'b0;
        halt_instr = 1'b1;
        #1;
        chk("lasthalt_pw", {31'd0, pc_write}, 32'd0);
        chk("lasthalt_db", {31'd0, db_we}, 32'd1);
        tick();
        halt_instr = 1'b0;
        chk("lasthalt_state", {30'd0, state}, 32'd3);
        chk("lasthalt_done", {31'd0, done}, 32'd1);
        tick();
        chk("lasthalt_single_done", {31'd0, done}, 32'd0);
        chk("lasthalt_cc", cycle_count, ecc(32'd5));
        set_cmd(CLEAR, 8'd0);
        tick();
        cmd_valid = 1'b0;
        chk("clear2_state", {30'd0, state}, 32'd0);

        // STOP and HALT together resolve to HALTED
        set_cmd(RUN, 8'd0);
        tick();
        set_cmd(STOP, 8'd0);
        halt_instr = 1'b1;
        tick();
        cmd_valid  = 1'b0;
        halt_instr = 1'b0;
        chk("stophalt_state", {30'd0, state}, 32'd3);
        chk("stophalt_done", {31'd0, done}, 32'd1);
        set_cmd(CLEAR, 8'd0);
        tick();
        cmd_valid = 1'b0;
        chk("clear3_pulse", {31'd0, pc_clear}, 32'd1);
        chk("clear3_cc", cycle_count, 32'd0);

        // Asynchronous reset mid-RUN
        set_cmd(RUN, 8'd0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_state", {30'd0, state}, 32'd0);
        chk("arst_db", {31'd0, db_we}, 32'd0);
        chk("arst_pw", {31'd0, pc_write}, 32'd0);
        chk("arst_pulses", {29'd0, done, cmd_err, pc_clear}, 32'd0);
        chk("arst_cc", cycle_count, 32'd0);
        tick();
        @(posedge clk);
        #3;
        rst = 1'b1;
        chk("arst_no_done", {31'd0, done}, 32'd0);
        set_cmd(RUN, 8'd0);
        tick();
        cmd_valid = 1'b0;
        chk("first_cmd_state", {30'd0, state}, 32'd1);
        chk("first_cmd_db", {31'd0, db_we}, 32'd1);

`ifdef PC_SEQ_CYCLE_COUNT_EN
        force dut.cycle_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_cnt_q;
        tick();
        chk("wrap_max", cycle_count, 32'hFFFF_FFFF);
        tick();
        chk("wrap_zero", cycle_count, 32'd0);
`else
        tick();
        tick();
        chk("cc_tied", cycle_count, 32'd0);
`endif

        set_cmd(STOP, 8'd0);
        tick();
        cmd_valid = 1'b0;
        chk("final_state", {30'd0, state}, 32'd0);
        chk("final_done", {31'd0, done}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
